// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes, FSM states
// and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Counter holds values up to WIDTH-1 with one spare bit so it can never wrap.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and result sign correction shared by the multiply and
// divide paths. i_split negates the two halves independently (remainder / quotient).
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_signed,
    input  logic [2*WIDTH-1:0] i_val,
    input  logic               i_split,
    input  logic               i_neg_hi,
    input  logic               i_neg_lo,
    output logic               o_sign_a,
    output logic               o_sign_b,
    output logic [WIDTH-1:0]   o_abs_a,
    output logic [WIDTH-1:0]   o_abs_b,
    output logic [2*WIDTH-1:0] o_val
);
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi_neg;
    logic [WIDTH-1:0]   w_lo_neg;
    logic [2*WIDTH-1:0] w_full_neg;

    assign o_sign_a = i_signed & i_a[WIDTH-1];
    assign o_sign_b = i_signed & i_b[WIDTH-1];
    assign o_abs_a  = o_sign_a ? -i_a : i_a;
    assign o_abs_b  = o_sign_b ? -i_b : i_b;

    assign w_hi       = i_val[2*WIDTH-1:WIDTH];
    assign w_lo       = i_val[WIDTH-1:0];
    assign w_hi_neg   = -w_hi;
    assign w_lo_neg   = -w_lo;
    assign w_full_neg = -i_val;

    always_comb begin
        o_val = i_val;
        if (i_split) begin
            o_val = {(i_neg_hi ? w_hi_neg : w_hi), (i_neg_lo ? w_lo_neg : w_lo)};
        end else if (i_neg_lo) begin
            o_val = w_full_neg;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MULDIV_DIV_EN to include the
// restoring divider (DIV/DIVU); without it those functs are reported as illegal.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           dbg_state
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [WIDTH-1:0]          r_hi;
    logic [WIDTH-1:0]          r_lo;
    logic [WIDTH-1:0]          r_mcand;
    logic [WIDTH-1:0]          r_acc_hi;
    logic [WIDTH-1:0]          r_acc_lo;
    logic                      r_done;
    logic                      r_illegal;
    logic                      r_neg_res;
    logic                      w_accept;
    logic                      w_signed_op;
    logic                      w_sign_a;
    logic                      w_sign_b;
    logic                      w_split;
    logic                      w_neg_hi;
    logic [WIDTH-1:0]          w_abs_a;
    logic [WIDTH-1:0]          w_abs_b;
    logic [2*WIDTH-1:0]        w_fix_val;
    logic [WIDTH+MUL_STEP-1:0] w_mul_sum;

`ifdef MULDIV_DIV_EN
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
    logic             r_is_div;
    logic             r_neg_rem;
    logic             r_b_zero;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_a_orig;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;

    assign w_signed_op = (req_funct == FN_MULT) || (req_funct == FN_DIV);
    assign w_split     = r_is_div;
    assign w_neg_hi    = r_neg_rem;
    assign div_zero    = r_div_zero;
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_mcand};
`else
    assign w_signed_op = (req_funct == FN_MULT);
    assign w_split     = 1'b0;
    assign w_neg_hi    = 1'b0;
    assign div_zero    = 1'b0;
`endif

    assign req_ready = (r_state == IDLE) && !flush;
    assign w_accept  = req_valid && req_ready;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign illegal   = r_illegal;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

    // r_acc_hi accumulates the product's upper half while r_acc_lo shifts the multiplier out.
    assign w_mul_sum = {{MUL_STEP{1'b0}}, r_acc_hi}
                     + ({{MUL_STEP{1'b0}}, r_mcand} * {{WIDTH{1'b0}}, r_acc_lo[MUL_STEP-1:0]});

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_a      (req_a),
        .i_b      (req_b),
        .i_signed (w_signed_op),
        .i_val    ({r_acc_hi, r_acc_lo}),
        .i_split  (w_split),
        .i_neg_hi (w_neg_hi),
        .i_neg_lo (r_neg_res),
        .o_sign_a (w_sign_a),
        .o_sign_b (w_sign_b),
        .o_abs_a  (w_abs_a),
        .o_abs_b  (w_abs_b),
        .o_val    (w_fix_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_orig   <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_div_zero <= 1'b0;
`endif
            if (flush) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_neg_res <= w_sign_a ^ w_sign_b;
                            r_acc_hi  <= '0;
                            case (req_funct)
                                FN_MULT, FN_MULTU: begin
                                    r_state  <= MUL;
                                    r_cnt    <= MUL_LAST;
                                    r_mcand  <= w_abs_a;
                                    r_acc_lo <= w_abs_b;
`ifdef MULDIV_DIV_EN
                                    r_is_div <= 1'b0;
`endif
                                end
`ifdef MULDIV_DIV_EN
                                FN_DIV, FN_DIVU: begin
                                    r_state   <= DIV;
                                    r_cnt     <= DIV_LAST;
                                    r_mcand   <= w_abs_b;
                                    r_acc_lo  <= w_abs_a;
                                    r_is_div  <= 1'b1;
                                    r_neg_rem <= w_sign_a;
                                    r_b_zero  <= (req_b == '0);
                                    r_a_orig  <= req_a;
                                end
`endif
                                FN_MTHI: begin
                                    r_hi   <= req_a;
                                    r_done <= 1'b1;
                                end
                                FN_MTLO: begin
                                    r_lo   <= req_a;
                                    r_done <= 1'b1;
                                end
                                default: r_illegal <= 1'b1;
                            endcase
                        end
                    end
                    MUL: begin
                        {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[WIDTH-1:MUL_STEP]};
                        if (r_cnt == '0) r_state <= FIX;
                        else             r_cnt   <= r_cnt - CW'(1);
                    end
`ifdef MULDIV_DIV_EN
                    DIV: begin
                        // Restoring step: keep the trial difference only when it did not borrow.
                        if (!w_div_trial[WIDTH]) begin
                            r_acc_hi <= w_div_trial[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc_hi <= w_div_shift[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                        end
                        if (r_cnt == '0) r_state <= FIX;
                        else             r_cnt   <= r_cnt - CW'(1);
                    end
`endif
                    FIX: begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (r_is_div && r_b_zero) begin
                            r_hi       <= r_a_orig;
                            r_lo       <= '1;
                            r_div_zero <= 1'b1;
                        end else
`endif
                        begin
                            {r_hi, r_lo} <= w_fix_val;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit (WIDTH=32, MUL_STEP=1 and 4), with
// an expected-result queue filled at issue time and drained on each done pulse.
module tb_muldiv_unit;
    localparam int W = 32;

    localparam logic [5:0] T_MULT  = 6'b011000;
    localparam logic [5:0] T_MULTU = 6'b011001;
    localparam logic [5:0] T_DIV   = 6'b011010;
    localparam logic [5:0] T_DIVU  = 6'b011011;
    localparam logic [5:0] T_MTHI  = 6'b010001;
    localparam logic [5:0] T_MTLO  = 6'b010011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         req_valid;
    logic         req_valid4;
    logic [5:0]   req_funct;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         flush;
    logic         req_ready, busy, done, div_zero, illegal;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;
    logic         req_ready4, busy4, done4, div_zero4, illegal4;
    logic [W-1:0] hi4, lo4;
    logic [1:0]   dbg_state4;

    logic [2*W:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_unit #(.WIDTH(W), .MUL_STEP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_a(req_a), .req_b(req_b), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero), .illegal(illegal),
        .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    muldiv_unit #(.WIDTH(W), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_funct(req_funct), .req_a(req_a), .req_b(req_b), .flush(flush),
        .busy(busy4), .done(done4), .div_zero(div_zero4), .illegal(illegal4),
        .hi(hi4), .lo(lo4), .dbg_state(dbg_state4)
    );

    task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb;
        logic [2*W-1:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (f)
            T_MULT:  p = 64'(sa * sb);
            T_MULTU: p = {32'h0, a} * {32'h0, b};
            T_DIV:   if (b == '0) return {1'b1, a, {W{1'b1}}};
                     else p = {W'(sa % sb), W'(sa / sb)};
            T_DIVU:  if (b == '0) return {1'b1, a, {W{1'b1}}};
                     else p = {a % b, a / b};
            default: p = {m_hi, m_lo};
        endcase
        return {1'b0, p};
    endfunction

    task automatic push_exp(input logic [2*W:0] e);
        exp_q.push_back(e);
        m_hi = e[2*W-1:W];
        m_lo = e[W-1:0];
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        check("ready at issue", req_ready, 1);
        req_funct = f; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = $urandom();
        req_b = $urandom();
    endtask

    task automatic pop_cmp(input string tag);
        logic [2*W:0] e;
        check({tag, " queue"}, (exp_q.size() > 0), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, " hi"}, hi, e[2*W-1:W]);
        check({tag, " lo"}, lo, e[W-1:0]);
        check({tag, " div_zero"}, div_zero, e[2*W]);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int   lat;
        logic busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy while running"}, busy_ok, 1);
        check({tag, " busy in done cycle"}, busy, 0);
        pop_cmp(tag);
    endtask

    task automatic illegal_case(input string tag, input logic [5:0] f);
        @(negedge clk);
        issue(f, 32'h7, 32'h2);
        @(negedge clk);
        check({tag, " illegal"}, illegal, 1);
        check({tag, " done"}, done, 0);
        check({tag, " hi"}, hi, m_hi);
        check({tag, " lo"}, lo, m_lo);
        check({tag, " ready"}, req_ready, 1);
        @(negedge clk);
        check({tag, " illegal cleared"}, illegal, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a, b;
        logic [5:0]   f;
        int           lat;
        logic         seen;

        rst_n = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; flush = 1'b0;
        req_funct = '0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst div_zero", div_zero, 0);
        check("rst illegal", illegal, 0);
        check("rst ready", req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        push_exp({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        issue(T_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult neg", 34);

        // Issued in the done cycle of the previous op.
        push_exp({1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        issue(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu max", 34);

        @(negedge clk);
        req_funct = T_MULTU; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done4) break;
        end
        check("step4 latency", lat, 10);
        check("step4 hi", hi4, 32'hFFFF_FFFE);
        check("step4 lo", lo4, 32'h0000_0001);

        for (int i = 0; i < 4; i++) begin
            a = $urandom();
            b = (i == 3) ? 32'h0 : $urandom();
            f = i[0] ? T_MULT : T_MULTU;
            push_exp(model(f, a, b));
            issue(f, a, b);
            wait_done("mul rand", 34);
        end

`ifdef MULDIV_DIV_EN
        push_exp({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(T_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div -7/2", 34);

        push_exp({1'b1, 32'h0000_0007, 32'hFFFF_FFFF});
        issue(T_DIVU, 32'd7, 32'd0);
        wait_done("divu by zero", 34);

        push_exp({1'b0, 32'h0000_0000, 32'h8000_0000});
        issue(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div min/-1", 34);

        for (int i = 0; i < 6; i++) begin
            a = $urandom();
            case ($urandom_range(0, 2))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 100);
                default: b = $urandom();
            endcase
            f = i[0] ? T_DIV : T_DIVU;
            push_exp(model(f, a, b));
            issue(f, a, b);
            wait_done("div rand", 34);
        end
`endif

        @(negedge clk);
        push_exp({1'b0, 32'h0000_1234, m_lo});
        req_funct = T_MTHI; req_a = 32'h1234; req_valid = 1'b1;
        @(posedge clk); #1;
        push_exp({1'b0, 32'h0000_1234, 32'h0000_5678});
        req_funct = T_MTLO; req_a = 32'h5678;
        @(negedge clk);
        check("mthi done", done, 1);
        pop_cmp("mthi");
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mtlo done", done, 1);
        pop_cmp("mtlo");
        @(negedge clk);
        check("mt done cleared", done, 0);

        issue(T_MULTU, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        check("flush masks ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush busy", busy, 0);
        check("flush ready", req_ready, 1);
        check("flush hi", hi, m_hi);
        check("flush lo", lo, m_lo);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        check("flush no done", seen, 0);

        flush = 1'b1; req_funct = T_MTHI; req_a = 32'hDEAD; req_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("flush beats accept hi", hi, m_hi);
        check("flush beats accept done", done, 0);

        illegal_case("funct 0", 6'b000000);
`ifndef MULDIV_DIV_EN
        illegal_case("div disabled", T_DIV);
`endif

        @(negedge clk);
`ifdef MULDIV_DIV_EN
        issue(T_DIV, 32'd100, 32'd7);
`else
        issue(T_MULTU, 32'd100, 32'd7);
`endif
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("mid rst hi", hi, 0);
        check("mid rst lo", lo, 0);
        check("mid rst busy", busy, 0);
        check("mid rst ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst done", done, 0);

        push_exp(model(T_MULTU, 32'd12345, 32'd678));
        issue(T_MULTU, 32'd12345, 32'd678);
        wait_done("post rst multu", 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
